// File: rtl/tile_job_serializer.sv
// Parallel tile-job loader that serializes address, zoom and multi-limb c_real/c_imag
// into the solver's typed 32-bit word stream; counts completed jobs.
module tile_job_serializer #(
    parameter int unsigned LIMB_INDEX_BITS = 6,
    parameter int unsigned LIMB_SIZE_BITS  = 8,
    parameter int unsigned MAX_LIMBS       = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                job_valid,
    output logic                                job_ready,
    input  logic [28:0]                         job_address,
    input  logic [28:0]                         job_zoom,
    input  logic [LIMB_INDEX_BITS-1:0]          job_num_limbs,
    input  logic [MAX_LIMBS*LIMB_SIZE_BITS-1:0] job_c_real,
    input  logic [MAX_LIMBS*LIMB_SIZE_BITS-1:0] job_c_imag,
    output logic                                out_valid,
    output logic [31:0]                         out_data,
    output logic                                out_end_of_stream,
    input  logic                                out_ready,
    output logic [15:0]                         jobs_sent
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADDR = 3'd1;
    localparam logic [2:0] ZOOM = 3'd2;
    localparam logic [2:0] REAL = 3'd3;
    localparam logic [2:0] IMAG = 3'd4;

    localparam int unsigned                 LW    = MAX_LIMBS * LIMB_SIZE_BITS;
    localparam logic [LIMB_INDEX_BITS-1:0] MAX_L = LIMB_INDEX_BITS'(MAX_LIMBS);
    localparam logic [LIMB_INDEX_BITS-1:0] ONE_L = LIMB_INDEX_BITS'(1);

    logic [2:0]                 state_q, state_d;
    logic [LIMB_INDEX_BITS-1:0] k_q, k_d;
    logic [LIMB_INDEX_BITS-1:0] nl_q, nl_d;
    logic [28:0]                addr_q, addr_d;
    logic [28:0]                zoom_q, zoom_d;
    logic [LW-1:0]              real_q, real_d;
    logic [LW-1:0]              imag_q, imag_d;
    logic [15:0]                jobs_sent_q, jobs_sent_d;

    logic                       last_limb;
    logic [LW-1:0]              limb_src;
    logic [LIMB_SIZE_BITS-1:0]  limb;

    assign last_limb = (k_q == nl_q - ONE_L);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        nl_d        = nl_q;
        addr_d      = addr_q;
        zoom_d      = zoom_q;
        real_d      = real_q;
        imag_d      = imag_q;
        jobs_sent_d = jobs_sent_q;
        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    addr_d  = job_address;
                    zoom_d  = job_zoom;
                    real_d  = job_c_real;
                    imag_d  = job_c_imag;
                    // zero or oversized limb counts fall back to the full width
                    nl_d    = (job_num_limbs == '0 || job_num_limbs > MAX_L) ? MAX_L : job_num_limbs;
                    k_d     = '0;
                    state_d = ADDR;
                end
            end
            ADDR: if (out_ready) state_d = ZOOM;
            ZOOM: begin
                if (out_ready) begin
                    state_d = REAL;
                    k_d     = '0;
                end
            end
            REAL: begin
                if (out_ready) begin
                    if (last_limb) begin
                        state_d = IMAG;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + ONE_L;
                    end
                end
            end
            IMAG: begin
                if (out_ready) begin
                    if (last_limb) begin
                        state_d     = IDLE;
                        k_d         = '0;
                        jobs_sent_d = jobs_sent_q + 16'd1;
                    end else begin
                        k_d = k_q + ONE_L;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        limb_src = (state_q == IMAG) ? imag_q : real_q;
        limb     = '0;
        for (int unsigned i = 0; i < MAX_LIMBS; i++) begin
            if (k_q == LIMB_INDEX_BITS'(i)) limb = limb_src[i*LIMB_SIZE_BITS +: LIMB_SIZE_BITS];
        end
    end

    always_comb begin
        out_data = '0;
        case (state_q)
            ADDR:    out_data = {3'd0, addr_q};
            ZOOM:    out_data = {3'd1, zoom_q};
            REAL:    out_data = {3'd2, 29'(limb)};
            IMAG:    out_data = {3'd3, 29'(limb)};
            default: out_data = '0;
        endcase
    end

    assign job_ready         = (state_q == IDLE);
    assign out_valid         = (state_q != IDLE);
    assign out_end_of_stream = (state_q == IMAG) && last_limb;
    assign jobs_sent         = jobs_sent_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            nl_q        <= '0;
            addr_q      <= '0;
            zoom_q      <= '0;
            real_q      <= '0;
            imag_q      <= '0;
            jobs_sent_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            nl_q        <= nl_d;
            addr_q      <= addr_d;
            zoom_q      <= zoom_d;
            real_q      <= real_d;
            imag_q      <= imag_d;
            jobs_sent_q <= jobs_sent_d;
        end
    end

endmodule

// File: tb/tb_tile_job_serializer.sv
// Scoreboard bench for tile_job_serializer: stimulus pushes expected words,
// a negedge monitor pops and compares each transferred word.
module tb_tile_job_serializer;

    typedef struct packed {
        logic [31:0] data;
        logic        eos;
    } word_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        job_valid;
    logic        job_ready;
    logic [28:0] job_address;
    logic [28:0] job_zoom;
    logic [5:0]  job_num_limbs;
    logic [31:0] job_c_real;
    logic [31:0] job_c_imag;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_end_of_stream;
    logic        out_ready;
    logic [15:0] jobs_sent;

    word_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          first_cyc = 0;
    int          job_span  = -1;
    int          last_eos_cyc = -100;
    int          gap = -1;
    logic        stalled = 1'b0;
    logic [31:0] held;
    logic [15:0] exp_jobs;

    tile_job_serializer #(
        .LIMB_INDEX_BITS(6),
        .LIMB_SIZE_BITS (8),
        .MAX_LIMBS      (4)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_address      (job_address),
        .job_zoom         (job_zoom),
        .job_num_limbs    (job_num_limbs),
        .job_c_real       (job_c_real),
        .job_c_imag       (job_c_imag),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_end_of_stream(out_end_of_stream),
        .out_ready        (out_ready),
        .jobs_sent        (jobs_sent)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every word accepted by downstream must match the head of the queue.
    always @(negedge clock) begin
        word_t w;
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_data, 32'hxxxxxxxx);
                end else begin
                    w = exp_q.pop_front();
                    chk("word_data", out_data, w.data);
                    chk("word_eos", {31'd0, out_end_of_stream}, {31'd0, w.eos});
                end
                if (out_data[31:29] == 3'd0) begin
                    first_cyc = cyc;
                    gap       = cyc - last_eos_cyc;
                end
                if (out_end_of_stream) begin
                    last_eos_cyc = cyc;
                    job_span     = cyc - first_cyc;
                end
            end
            if (stalled) chk("stall_valid", {31'd0, out_valid}, 32'd1);
            if (out_valid && !out_ready) begin
                if (stalled) chk("stall_hold", out_data, held);
                held    = out_data;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic push(input logic [31:0] d, input logic e);
        word_t w;
        w.data = d;
        w.eos  = e;
        exp_q.push_back(w);
    endtask

    task automatic expect_job(input logic [28:0] a, input logic [28:0] z, input int leff,
                              input logic [31:0] r, input logic [31:0] im);
        push({3'd0, a}, 1'b0);
        push({3'd1, z}, 1'b0);
        for (int k = 0; k < leff; k++) push({3'd2, 21'd0, r[k*8 +: 8]}, 1'b0);
        for (int k = 0; k < leff; k++) push({3'd3, 21'd0, im[k*8 +: 8]}, k == leff - 1);
    endtask

    task automatic scramble();
        job_address   = 29'($urandom);
        job_zoom      = 29'($urandom);
        job_num_limbs = 6'($urandom);
        job_c_real    = $urandom;
        job_c_imag    = $urandom;
    endtask

    task automatic send_job(input logic [28:0] a, input logic [28:0] z, input logic [5:0] nl,
                            input logic [31:0] r, input logic [31:0] im);
        int t;
        @(negedge clock);
        job_address   = a;
        job_zoom      = z;
        job_num_limbs = nl;
        job_c_real    = r;
        job_c_imag    = im;
        job_valid     = 1'b1;
        t = 0;
        while (!job_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!job_ready) chk("accept_timeout", {31'd0, job_ready}, 32'd1);
        @(posedge clock);
        #1;
        job_valid = 1'b0;
        scramble();
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        @(negedge clock);
        while (!(exp_q.size() == 0 && job_ready) && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        int t;
        reset     = 1'b0;
        job_valid = 1'b0;
        out_ready = 1'b1;
        scramble();
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, job_ready}, 32'd1);
        chk("rst_eos", {31'd0, out_end_of_stream}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_jobs", {16'd0, jobs_sent}, 32'd0);
        exp_jobs = 16'd0;
        @(negedge clock);
        reset = 1'b1;

        // Basic job, hand-listed word sequence
        push(32'h00000001, 1'b0); push(32'h20000002, 1'b0);
        push(32'h40000003, 1'b0); push(32'h40000004, 1'b0); push(32'h40000005, 1'b0);
        push(32'h60000006, 1'b0); push(32'h60000007, 1'b0); push(32'h60000008, 1'b1);
        send_job(29'd1, 29'd2, 6'd3, 32'h00050403, 32'h00080706);
        wait_done();
        chk("basic_span", job_span, 32'd7);
        exp_jobs = exp_jobs + 16'd1;
        chk("basic_jobs", {16'd0, jobs_sent}, {16'd0, exp_jobs});

        // Backpressure on the second c_imag word
        push(32'h00000001, 1'b0); push(32'h20000002, 1'b0);
        push(32'h40000003, 1'b0); push(32'h40000004, 1'b0); push(32'h40000005, 1'b0);
        push(32'h60000006, 1'b0); push(32'h60000007, 1'b0); push(32'h60000008, 1'b1);
        send_job(29'd1, 29'd2, 6'd3, 32'h00050403, 32'h00080706);
        t = 0;
        while (out_data != 32'h60000007 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("bp_data", out_data, 32'h60000007);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        wait_done();
        exp_jobs = exp_jobs + 16'd1;
        chk("bp_jobs", {16'd0, jobs_sent}, {16'd0, exp_jobs});

        // Limb clamp: L=0 and L=7 both become 4
        expect_job(29'h0ABCDEF, 29'h1000000, 4, 32'h44332211, 32'h88776655);
        send_job(29'h0ABCDEF, 29'h1000000, 6'd0, 32'h44332211, 32'h88776655);
        wait_done();
        expect_job(29'd7, 29'd9, 4, 32'hDDCCBBAA, 32'h01020304);
        send_job(29'd7, 29'd9, 6'd7, 32'hDDCCBBAA, 32'h01020304);
        wait_done();

        // L=1, upper limbs ignored
        push(32'h001ABCDE, 1'b0); push(32'h20000005, 1'b0);
        push(32'h4000009A, 1'b0); push(32'h600000BC, 1'b1);
        send_job(29'h1ABCDE, 29'd5, 6'd1, 32'hFFFFFF9A, 32'h123456BC);
        wait_done();
        exp_jobs = exp_jobs + 16'd3;
        chk("clamp_jobs", {16'd0, jobs_sent}, {16'd0, exp_jobs});

        // Back-to-back with job_valid held high
        expect_job(29'd10, 29'd11, 2, 32'h00000201, 32'h00000403);
        expect_job(29'd20, 29'd21, 1, 32'h00000055, 32'h00000066);
        @(negedge clock);
        job_address = 29'd10; job_zoom = 29'd11; job_num_limbs = 6'd2;
        job_c_real = 32'h00000201; job_c_imag = 32'h00000403;
        job_valid = 1'b1;
        @(posedge clock);
        #1;
        job_address = 29'd20; job_zoom = 29'd21; job_num_limbs = 6'd1;
        job_c_real = 32'h00000055; job_c_imag = 32'h00000066;
        @(negedge clock);
        chk("b2b_ready_low0", {31'd0, job_ready}, 32'd0);
        @(negedge clock);
        chk("b2b_ready_low1", {31'd0, job_ready}, 32'd0);
        t = 0;
        while (!job_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        @(posedge clock);
        #1;
        job_valid = 1'b0;
        scramble();
        wait_done();
        chk("b2b_gap", gap, 32'd2);
        exp_jobs = exp_jobs + 16'd2;
        chk("b2b_jobs", {16'd0, jobs_sent}, {16'd0, exp_jobs});

        // Asynchronous reset during REAL
        expect_job(29'd3, 29'd4, 3, 32'h00030201, 32'h00060504);
        send_job(29'd3, 29'd4, 6'd3, 32'h00030201, 32'h00060504);
        t = 0;
        while (out_data[31:29] != 3'd2 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_jobs", {16'd0, jobs_sent}, 32'd0);
        chk("mid_rst_ready", {31'd0, job_ready}, 32'd1);
        exp_q.delete();
        exp_jobs = 16'd0;
        @(negedge clock);
        reset = 1'b1;
        expect_job(29'd30, 29'd31, 2, 32'h0000A1A0, 32'h0000B1B0);
        send_job(29'd30, 29'd31, 6'd2, 32'h0000A1A0, 32'h0000B1B0);
        wait_done();
        exp_jobs = exp_jobs + 16'd1;
        chk("post_rst_jobs", {16'd0, jobs_sent}, {16'd0, exp_jobs});

        // Counter wrap, starting from a preloaded count
        @(negedge clock);
        force dut.jobs_sent_q = 16'hFFFE;
        @(negedge clock);
        release dut.jobs_sent_q;
        exp_jobs = 16'hFFFE;
        for (int j = 0; j < 2; j++) begin
            expect_job(29'd1, 29'd1, 1, 32'h00000011, 32'h00000022);
            send_job(29'd1, 29'd1, 6'd1, 32'h00000011, 32'h00000022);
            wait_done();
            exp_jobs = exp_jobs + 16'd1;
            chk("wrap_jobs", {16'd0, jobs_sent}, {16'd0, exp_jobs});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
